ad_fifo_uart_sched: RTL and testbench

//  Read-side scheduler for the 8-bit AD FIFO filled by the channel-polling controller.

---
 rtl/ad_fifo_uart_sched.sv | 150 +++++++++++++++
 tb/tb_ad_fifo_uart_sched.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad_fifo_uart_sched.sv
`default_nettype none
// ============================================================================
//  Module      : ad_fifo_uart_sched
//  Description : Drains the AD FIFO into a byte-wide UART as header-prefixed
//                frames that close on CR/LF, FIFO empty or a length limit.
//  Revision    : 1.0 - initial release
// ============================================================================
module ad_fifo_uart_sched #(
    parameter logic [7:0]  HDR_BYTE  = 8'hAA,
    parameter logic [15:0] WM_LEVEL  = 16'd64,
    parameter logic [31:0] TIMEOUT   = 32'd5_000_000,
    parameter logic [15:0] MAX_BYTES = 16'd1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        fifo_empty,
    input  logic [15:0] fifo_usedw,
    input  logic [7:0]  fifo_q,
    output logic        fifo_rdreq,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic [15:0] byte_cnt,
    output logic        frame_done,
    output logic [2:0]  sched_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_RD   = 3'd2,
        S_LAT  = 3'd3,
        S_SEND = 3'd4,
        S_TXW  = 3'd5,
        S_END  = 3'd6
    } state_t;

    localparam logic [7:0]  c_CR      = 8'h0D;
    localparam logic [7:0]  c_LF      = 8'h0A;
    localparam logic [31:0] c_TO_MAX  = 32'hFFFF_FFFF;
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    state_t      r_state;
    logic [31:0] r_to_cnt;
    logic        r_prev_0d;
    logic        r_crlf;
    logic        r_txw_first;
    logic        r_after_hdr;
    logic [7:0]  r_tx_data;
    logic [15:0] r_byte_cnt;

    logic        w_start_frame;
    logic        w_tx_start;
    logic        w_rdreq;
    logic        w_frame_end;

    assign w_start_frame = enable &&
                           ((fifo_usedw >= WM_LEVEL) || (!fifo_empty && (r_to_cnt >= TIMEOUT)));
    assign w_tx_start    = ((r_state == S_HDR) || (r_state == S_SEND)) && !tx_busy;
    assign w_rdreq       = (r_state == S_RD) && enable && !fifo_empty;
    assign w_frame_end   = r_crlf || (r_byte_cnt == MAX_BYTES);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_to_cnt    <= 32'd0;
            r_prev_0d   <= 1'b0;
            r_crlf      <= 1'b0;
            r_txw_first <= 1'b0;
            r_after_hdr <= 1'b0;
            r_tx_data   <= 8'd0;
            r_byte_cnt  <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_frame) begin
                        r_state    <= S_HDR;
                        r_tx_data  <= HDR_BYTE;
                        r_byte_cnt <= 16'd0;
                        r_prev_0d  <= 1'b0;
                        r_crlf     <= 1'b0;
                        r_to_cnt   <= 32'd0;
                    end else if (fifo_empty) begin
                        r_to_cnt <= 32'd0;
                    end else if (r_to_cnt != c_TO_MAX) begin
                        r_to_cnt <= r_to_cnt + 32'd1;
                    end
                end
                S_HDR: begin
                    if (w_tx_start) begin
                        r_state     <= S_TXW;
                        r_txw_first <= 1'b1;
                        r_after_hdr <= 1'b1;
                    end
                end
                S_RD: begin
                    if (!enable || fifo_empty) begin
                        r_state <= S_END;
                    end else begin
                        r_state <= S_LAT;
                    end
                end
                S_LAT: begin
                    r_tx_data <= fifo_q;
                    r_state   <= S_SEND;
                end
                S_SEND: begin
                    if (w_tx_start) begin
                        if (r_byte_cnt != c_CNT_MAX) begin
                            r_byte_cnt <= r_byte_cnt + 16'd1;
                        end
                        // CR/LF pair is judged against the previous byte's flag before it is overwritten
                        r_crlf      <= r_prev_0d && (r_tx_data == c_LF);
                        r_prev_0d   <= (r_tx_data == c_CR);
                        r_state     <= S_TXW;
                        r_txw_first <= 1'b1;
                        r_after_hdr <= 1'b0;
                    end
                end
                S_TXW: begin
                    if (r_txw_first) begin
                        r_txw_first <= 1'b0;
                    end else if (!tx_busy) begin
                        if (!r_after_hdr && w_frame_end) begin
                            r_state <= S_END;
                        end else begin
                            r_state <= S_RD;
                        end
                    end
                end
                S_END: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign fifo_rdreq  = w_rdreq;
    assign tx_start    = w_tx_start;
    assign frame_done  = (r_state == S_END);
    assign tx_data     = r_tx_data;
    assign byte_cnt    = r_byte_cnt;
    assign sched_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ad_fifo_uart_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ad_fifo_uart_sched
//  Description : Self-checking bench with FIFO and UART models and a byte scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ad_fifo_uart_sched;

    localparam logic [7:0]  c_HDR  = 8'hAA;
    localparam logic [15:0] c_WM   = 16'd64;
    localparam logic [31:0] c_TO   = 32'd100;
    localparam int          c_MAXB = 64;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        fifo_empty;
    logic [15:0] fifo_usedw;
    logic [7:0]  fifo_q;
    logic        fifo_rdreq;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [15:0] byte_cnt;
    logic        frame_done;
    logic [2:0]  sched_state;

    ad_fifo_uart_sched #(
        .HDR_BYTE  (c_HDR),
        .WM_LEVEL  (c_WM),
        .TIMEOUT   (c_TO),
        .MAX_BYTES (16'(c_MAXB))
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .fifo_empty  (fifo_empty),
        .fifo_usedw  (fifo_usedw),
        .fifo_q      (fifo_q),
        .fifo_rdreq  (fifo_rdreq),
        .tx_busy     (tx_busy),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .byte_cnt    (byte_cnt),
        .frame_done  (frame_done),
        .sched_state (sched_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: normal mode, q registered on rdreq
    logic [7:0]  mem [0:4095];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    logic [15:0] count  = 16'd0;
    logic        wr_en;
    logic [7:0]  wr_data;
    initial fifo_q = 8'd0;

    always @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[11:0]] <= wr_data;
            wr_ptr <= wr_ptr + 1;
        end
        if (fifo_rdreq) begin
            fifo_q <= mem[rd_ptr[11:0]];
            rd_ptr <= rd_ptr + 1;
        end
        count <= count + (wr_en ? 16'd1 : 16'd0) - (fifo_rdreq ? 16'd1 : 16'd0);
    end
    assign fifo_empty = (count == 16'd0);
    assign fifo_usedw = count;

    // UART model: busy rises the cycle after start for busy_len cycles
    int busy_len;
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (tx_start) busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int frame_bytes = 0;
    logic        lat_arm = 1'b0;
    int          ne_cyc;
    int          hdr_cyc;
    logic [7:0]  exp_q[$];
    logic [7:0]  pay[$];
    int          exp_frames[$];
    logic [15:0] got_frames[$];

    typedef struct {
        int         n;
        logic [7:0] base;
        logic [7:0] step;
        int         busy;
        int         nfr;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: illegal condition (t=%0t)", name, $time);
    endtask

    task automatic monitor();
        logic [7:0] e;
        if (fifo_rdreq && fifo_empty) flag("rdreq_while_empty");
        if (fifo_rdreq && sched_state == 3'd5) flag("rdreq_in_txw");
        if (lat_arm) begin
            if (ne_cyc < 0 && !fifo_empty) ne_cyc = cyc;
            if (hdr_cyc < 0 && tx_start && sched_state == 3'd1) hdr_cyc = cyc;
        end
        if (tx_start) begin
            if (sched_state == 3'd1) begin
                chk("hdr_byte", {24'd0, tx_data}, {24'd0, c_HDR});
                frame_bytes = 0;
            end else if (exp_q.size() == 0) begin
                flag("extra_tx_byte");
            end else begin
                e = exp_q.pop_front();
                chk("tx_byte", {24'd0, tx_data}, {24'd0, e});
                frame_bytes++;
            end
        end
        if (frame_done) begin
            got_frames.push_back(byte_cnt);
            chk("frame_byte_cnt", {16'd0, byte_cnt}, frame_bytes);
        end
        cyc++;
    endtask

    task automatic tick();
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        exp_q.push_back(b);
        pay.push_back(b);
        tick();
        wr_en   = 1'b0;
    endtask

    // Frame split a preloaded payload: close on CR/LF, on the length limit, or at the end
    task automatic build_exp();
        int  n;
        logic p0;
        exp_frames.delete();
        n  = 0;
        p0 = 1'b0;
        foreach (pay[i]) begin
            n++;
            if ((p0 && pay[i] == 8'h0A) || n == c_MAXB) begin
                exp_frames.push_back(n);
                n  = 0;
                p0 = 1'b0;
            end else begin
                p0 = (pay[i] == 8'h0D);
            end
        end
        if (n > 0) exp_frames.push_back(n);
    endtask

    task automatic wait_frames(input string name, input int n, input int budget);
        int k;
        k = 0;
        while (got_frames.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (got_frames.size() < n) flag({name, "_timeout"});
        repeat (3) tick();
    endtask

    task automatic check_frames(input string name);
        chk({name, "_nframes"}, got_frames.size(), exp_frames.size());
        for (int i = 0; i < exp_frames.size() && i < got_frames.size(); i++)
            chk({name, "_frame_len"}, {16'd0, got_frames[i]}, exp_frames[i]);
        chk({name, "_leftover"}, exp_q.size(), 0);
    endtask

    task automatic new_test();
        pay.delete();
        got_frames.delete();
        exp_frames.delete();
    endtask

    task automatic wait_payload(input int n, input int budget);
        int k;
        k = 0;
        while (!(frame_bytes == n && sched_state == 3'd5) && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) flag("wait_payload_timeout");
    endtask

    initial begin
        vecs[0] = '{n: 64,  base: 8'h00, step: 8'h01, busy: 10,  nfr: 1};
        vecs[1] = '{n: 3,   base: 8'h40, step: 8'h01, busy: 10,  nfr: 1};
        vecs[2] = '{n: 150, base: 8'h80, step: 8'h01, busy: 10,  nfr: 3};
        vecs[3] = '{n: 3,   base: 8'hC0, step: 8'h07, busy: 500, nfr: 1};

        reset_n  = 1'b0;
        enable   = 1'b0;
        wr_en    = 1'b0;
        wr_data  = 8'd0;
        busy_len = 10;
        ne_cyc   = -1;
        hdr_cyc  = -1;
        repeat (3) tick();
        chk("rst_rdreq",  {31'd0, fifo_rdreq}, 0);
        chk("rst_start",  {31'd0, tx_start}, 0);
        chk("rst_data",   {24'd0, tx_data}, 0);
        chk("rst_cnt",    {16'd0, byte_cnt}, 0);
        chk("rst_done",   {31'd0, frame_done}, 0);
        chk("rst_state",  {29'd0, sched_state}, 0);
        reset_n = 1'b1;
        enable  = 1'b1;
        tick();

        for (int t = 0; t < 4; t++) begin
            new_test();
            busy_len = vecs[t].busy;
            for (int i = 0; i < vecs[t].n; i++) push(vecs[t].base + 8'(i) * vecs[t].step);
            build_exp();
            wait_frames("tbl", vecs[t].nfr, 40000);
            chk("tbl_nframes_vec", got_frames.size(), vecs[t].nfr);
            check_frames("tbl");
        end
        busy_len = 10;

        // Timeout start latency measured from the first non-empty cycle
        new_test();
        ne_cyc  = -1;
        hdr_cyc = -1;
        lat_arm = 1'b1;
        push(8'h51); push(8'h52); push(8'h53);
        build_exp();
        wait_frames("lat", 1, 2000);
        lat_arm = 1'b0;
        chk("timeout_latency", hdr_cyc - ne_cyc, 101);
        check_frames("lat");

        // CR/LF closes a frame, the trailing byte goes in a new frame
        new_test();
        push(8'h11); push(8'h22); push(8'h0D); push(8'h0A); push(8'h33);
        build_exp();
        wait_frames("crlf", 2, 3000);
        chk("crlf_first_len", got_frames.size() > 0 ? {16'd0, got_frames[0]} : 32'hFFFF_FFFF, 4);
        check_frames("crlf");

        // enable dropped mid-byte: byte completes, frame closes, rest waits
        new_test();
        for (int i = 0; i < 64; i++) push(8'(8'h20 + i));
        wait_payload(5, 5000);
        enable = 1'b0;
        wait_frames("en_drop", 1, 2000);
        repeat (300) tick();
        chk("en_drop_idle", {29'd0, sched_state}, 0);
        chk("en_drop_fifo", {16'd0, count}, 59);
        enable = 1'b1;
        wait_frames("en_resume", 2, 5000);
        exp_frames.push_back(5);
        exp_frames.push_back(59);
        check_frames("en");

        // Reset during S_TXW with 10 bytes left in the FIFO
        new_test();
        for (int i = 0; i < 64; i++) push(8'(8'h90 + i));
        wait_payload(54, 5000);
        reset_n = 1'b0;
        tick();
        chk("mid_rst_state", {29'd0, sched_state}, 0);
        chk("mid_rst_data",  {24'd0, tx_data}, 0);
        chk("mid_rst_cnt",   {16'd0, byte_cnt}, 0);
        chk("mid_rst_start", {31'd0, tx_start}, 0);
        chk("mid_rst_rdreq", {31'd0, fifo_rdreq}, 0);
        chk("mid_rst_done",  {31'd0, frame_done}, 0);
        chk("mid_rst_fifo",  {16'd0, count}, 10);
        reset_n = 1'b1;
        wait_frames("post_rst", 1, 2000);
        exp_frames.push_back(10);
        check_frames("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
